sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 36 +++
 rtl/sram_watchdog.sv | 43 ++++
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and default constants for the two-port SRAM
//               arbiter and its watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  // Default bus widths
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int LINE_W_DEF  = 64;

  // Watchdog defaults: busy-cycle limit and counter width
  localparam int TIMEOUT_DEF = 1023;
  localparam int CNT_W       = 10;

  // Arbiter state encoding; 2'd3 is illegal and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } arb_state_t;

  // One-hot grant value presented for a given state
  function automatic logic [1:0] grant_of(input arb_state_t st);
    case (st)
      ST_BUSY0: grant_of = 2'b01;
      ST_BUSY1: grant_of = 2'b10;
      default:  grant_of = 2'b00;
    endcase
  endfunction

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sram_watchdog
// Description : Busy-cycle counter for the SRAM arbiter. Cleared when a
//               transaction is granted, counts every busy cycle and flags
//               expire when the count reaches TIMEOUT. TIMEOUT=0 disables it.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_watchdog
  import sram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT != 0) begin : g_wd_on
      logic [CNT_W-1:0] busy_cnt;

      // Busy counter: zeroed on grant, advances once per busy cycle
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          busy_cnt <= '0;
        end else if (clear) begin
          busy_cnt <= '0;
        end else if (enable) begin
          busy_cnt <= busy_cnt + 1'b1;
        end
      end

      assign expire = enable && (busy_cnt == CNT_W'(TIMEOUT));
    end else begin : g_wd_off
      assign expire = 1'b0;
    end
  endgenerate

endmodule : sram_watchdog
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Round-robin arbiter sharing one SRAM controller between two
//               masters. Forwards the owner's request combinationally,
//               returns sram_ready as a one-cycle pulse to the owner only and
//               aborts transactions that exceed the watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // Port 0 (data cache)
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_read,
  input  logic              m0_write,
  output logic [LINE_W-1:0] m0_rdata,
  output logic              m0_ready,
  // Port 1 (fetch / DMA)
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_read,
  input  logic              m1_write,
  output logic [LINE_W-1:0] m1_rdata,
  output logic              m1_ready,
  // SRAM controller side
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_read,
  output logic              sram_write,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready,
  // Status
  output logic [1:0]        grant,
  output logic              timeout_err
);

  arb_state_t state;
  logic       last_grant;
  logic       req0, req1;
  logic       busy0, busy1;
  logic       start;
  logic       expire;
  logic       timeout_hit;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign busy0 = (state == ST_BUSY0);
  assign busy1 = (state == ST_BUSY1);
  assign start = (state == ST_IDLE) && (req0 || req1);

  // A real completion in the expiry cycle wins over the timeout
  assign timeout_hit = expire && !sram_ready;

  // Ready goes to the owner only; expiry also completes the transaction
  assign m0_ready = busy0 && (sram_ready || expire);
  assign m1_ready = busy1 && (sram_ready || expire);

  // Read block is shared, zeroed only in the timeout cycle
  assign m0_rdata = timeout_hit ? '0 : sram_rdata;
  assign m1_rdata = timeout_hit ? '0 : sram_rdata;

  sram_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (busy0 || busy1),
    .expire (expire)
  );

  // Forward the owner's request; write wins when both read and write are set
  always_comb begin
    sram_address = '0;
    sram_wdata   = '0;
    sram_read    = 1'b0;
    sram_write   = 1'b0;
    if (busy0) begin
      sram_address = m0_address;
      sram_wdata   = m0_wdata;
      sram_write   = m0_write;
      sram_read    = m0_read && !m0_write;
    end else if (busy1) begin
      sram_address = m1_address;
      sram_wdata   = m1_wdata;
      sram_write   = m1_write;
      sram_read    = m1_read && !m1_write;
    end
  end

  // Arbitration FSM with round-robin pointer, registered grant and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      grant       <= 2'b00;
      last_grant  <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          // On a tie the port that did not win last time is served
          if (req0 && (!req1 || last_grant)) begin
            state      <= ST_BUSY0;
            grant      <= grant_of(ST_BUSY0);
            last_grant <= 1'b0;
          end else if (req1) begin
            state      <= ST_BUSY1;
            grant      <= grant_of(ST_BUSY1);
            last_grant <= 1'b1;
          end
        end
        ST_BUSY0: begin
          // Completion, timeout or owner abort all return to IDLE
          if (m0_ready || !req0) begin
            state <= ST_IDLE;
            grant <= grant_of(ST_IDLE);
          end
        end
        ST_BUSY1: begin
          if (m1_ready || !req1) begin
            state <= ST_IDLE;
            grant <= grant_of(ST_IDLE);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= grant_of(ST_IDLE);
        end
      endcase
    end
  end

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter: directed scenarios plus
//               randomized two-master traffic against a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 64;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] m0_address, m1_address, sram_address;
  logic [DW-1:0] m0_wdata, m1_wdata, sram_wdata;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [LW-1:0] m0_rdata, m1_rdata, sram_rdata;
  logic          m0_ready, m1_ready;
  logic          sram_read, sram_write, sram_ready;
  logic [1:0]    grant;
  logic          timeout_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: owner -1 = nobody
  int mo_owner = -1;
  int mo_last  = 1;
  int mo_cnt   = 0;
  bit mo_err   = 0;

  // Snapshot of DUT outputs from the most recent cycle
  logic [1:0]    s_grant;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_rd, s_wr, s_rdy0, s_rdy1, s_err;
  logic [LW-1:0] s_rdata0;

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_read(m0_read),
    .m0_write(m0_write), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_read(m1_read),
    .m1_write(m1_write), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample at negedge, compare against the model, then advance the model
  task automatic cycle();
    bit            req[2];
    bit            rd[2], wr[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    bit            tnow, e_rdy0, e_rdy1;
    logic [1:0]    e_grant;
    @(negedge clk);
    rd[0] = m0_read;  wr[0] = m0_write; a[0] = m0_address; d[0] = m0_wdata;
    rd[1] = m1_read;  wr[1] = m1_write; a[1] = m1_address; d[1] = m1_wdata;
    req[0] = rd[0] || wr[0];
    req[1] = rd[1] || wr[1];
    e_grant = (mo_owner == 0) ? 2'b01 : (mo_owner == 1) ? 2'b10 : 2'b00;
    tnow    = (mo_owner >= 0) && (mo_cnt == TO) && !sram_ready;
    e_rdy0  = (mo_owner == 0) && (sram_ready || tnow);
    e_rdy1  = (mo_owner == 1) && (sram_ready || tnow);
    check("grant", grant, e_grant);
    check("timeout_err", timeout_err, mo_err);
    check("m0_ready", m0_ready, e_rdy0);
    check("m1_ready", m1_ready, e_rdy1);
    check("m0_rdata", m0_rdata, tnow ? 64'd0 : sram_rdata);
    check("m1_rdata", m1_rdata, tnow ? 64'd0 : sram_rdata);
    if (mo_owner >= 0) begin
      check("sram_address", sram_address, a[mo_owner]);
      check("sram_wdata", sram_wdata, d[mo_owner]);
      check("sram_write", sram_write, wr[mo_owner]);
      check("sram_read", sram_read, rd[mo_owner] && !wr[mo_owner]);
    end else begin
      check("idle_address", sram_address, 0);
      check("idle_wdata", sram_wdata, 0);
      check("idle_write", sram_write, 0);
      check("idle_read", sram_read, 0);
    end
    s_grant = grant; s_addr = sram_address; s_wdata = sram_wdata;
    s_rd = sram_read; s_wr = sram_write; s_rdy0 = m0_ready; s_rdy1 = m1_ready;
    s_rdata0 = m0_rdata; s_err = timeout_err;
    if (mo_owner < 0) begin
      if (req[0] && req[1]) mo_owner = (mo_last == 0) ? 1 : 0;
      else if (req[0])      mo_owner = 0;
      else if (req[1])      mo_owner = 1;
      if (mo_owner >= 0) begin
        mo_last = mo_owner;
        mo_cnt  = 0;
      end
    end else begin
      if (tnow) mo_err = 1;
      if (sram_ready || tnow || !req[mo_owner]) mo_owner = -1;
      else mo_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_wdata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_wdata = '0;
    sram_ready = 0; sram_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    mo_owner = -1; mo_last = 1; mo_cnt = 0; mo_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Random master behaviour: hold until ready, sometimes abort
  task automatic pick(input logic done, inout logic rd, inout logic wr,
                      inout logic [AW-1:0] a, inout logic [DW-1:0] d);
    int r;
    if (done || !(rd || wr)) begin
      if ($urandom_range(0, 1) == 1) begin
        r  = $urandom_range(1, 3);
        rd = r[0];
        wr = r[1];
        a  = $urandom;
        d  = $urandom;
      end else begin
        rd = 0;
        wr = 0;
      end
    end else if ($urandom_range(0, 39) == 0) begin
      rd = 0;
      wr = 0;
    end
  endtask

  initial begin
    int n;
    bit seen;
    clear_inputs();
    rst = 1'b0;
    #12;
    check("rst_grant", grant, 2'b00);
    check("rst_sram_read", sram_read, 0);
    check("rst_sram_write", sram_write, 0);
    check("rst_err", timeout_err, 0);
    do_reset();

    // Port 0 read, ready on 5th busy cycle
    m0_read = 1; m0_address = 32'h0000_0108;
    cycle();
    cycle();
    check("A_grant", s_grant, 2'b01);
    check("A_addr", s_addr, 32'h108);
    check("A_rd", s_rd, 1);
    repeat (3) cycle();
    sram_ready = 1; sram_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    cycle();
    check("A_rdy0", s_rdy0, 1);
    check("A_rdata", s_rdata0, 64'hAAAA_BBBB_CCCC_DDDD);
    check("A_rdy1", s_rdy1, 0);
    m0_read = 0; sram_ready = 0;
    cycle();
    check("A_idle", s_grant, 2'b00);

    // Simultaneous requests after reset alternate, port 0 first
    do_reset();
    m0_read = 1; m1_read = 1; m0_address = 32'h10; m1_address = 32'h20;
    cycle();
    sram_ready = 1;
    cycle();
    check("B_first", s_grant, 2'b01);
    m0_read = 0; sram_ready = 0;
    cycle();
    check("B_gap", s_grant, 2'b00);
    sram_ready = 1;
    cycle();
    check("B_second", s_grant, 2'b10);
    check("B_rdy1", s_rdy1, 1);
    m0_read = 1; sram_ready = 0;
    cycle();
    sram_ready = 1;
    cycle();
    check("B_third", s_grant, 2'b01);
    m0_read = 0; m1_read = 0; sram_ready = 0;
    cycle();

    // Port 1 with read and write both set: write forwarded
    m1_read = 1; m1_write = 1; m1_wdata = 32'h1234_5678;
    cycle();
    sram_ready = 1;
    cycle();
    check("C_wr", s_wr, 1);
    check("C_rd", s_rd, 0);
    check("C_wdata", s_wdata, 32'h1234_5678);
    m1_read = 0; m1_write = 0; sram_ready = 0;
    cycle();

    // Watchdog expiry with no sram_ready
    m0_read = 1; m0_address = 32'h40;
    cycle();
    n = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cycle();
      if (s_rdy0) begin
        seen = 1;
        n = i;
        check("D_rdata", s_rdata0, 64'd0);
      end
    end
    check("D_cycle", n, 9);
    m0_read = 0;
    cycle();
    check("D_err", s_err, 1);
    check("D_idle", s_grant, 2'b00);
    m1_write = 1;
    cycle();
    sram_ready = 1;
    cycle();
    m1_write = 0; sram_ready = 0;
    cycle();
    check("D_sticky", s_err, 1);

    // Asynchronous reset on the 3rd busy cycle of port 1
    m1_read = 1;
    repeat (3) cycle();
    #1 rst = 1'b0;
    #1;
    check("E_grant", grant, 2'b00);
    check("E_read", sram_read, 0);
    check("E_rdy1", m1_ready, 0);
    check("E_err", timeout_err, 0);
    do_reset();
    m0_read = 1; m1_read = 1;
    cycle();
    sram_ready = 1;
    cycle();
    check("E_tie", s_grant, 2'b01);
    m0_read = 0; m1_read = 0; sram_ready = 0;
    cycle();

    // Owner abort hands the bus to the pending port
    do_reset();
    m0_read = 1;
    cycle();
    cycle();
    m1_read = 1;
    cycle();
    m0_read = 0;
    cycle();
    check("F_no_rdy", s_rdy0, 0);
    cycle();
    check("F_rd_off", s_rd, 0);
    check("F_gap", s_grant, 2'b00);
    sram_ready = 1;
    cycle();
    check("F_grant1", s_grant, 2'b10);
    m1_read = 0; sram_ready = 0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      pick(s_rdy0, m0_read, m0_write, m0_address, m0_wdata);
      pick(s_rdy1, m1_read, m1_write, m1_address, m1_wdata);
      sram_ready = ($urandom_range(0, 4) == 0);
      sram_rdata = {$urandom, $urandom};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sram_arbiter
`default_nettype wire
